apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
- Two-requester APB master that shares one APB bus between two internal clients, e.g. the test sequencer and a config loader.
- Arbitrates round-robin and sequences each granted request through the APB IDLE/SETUP/ACCESS phases.
- Drives the bus signals consumed by the APB slave, returns read data and error status to the winning requester, and aborts transfers whose pready never arrives.

Parameters:
- ADDR_W, 8, width of paddr and requester addresses.
- DATA_W, 32, width of pwdata/prdata and requester data.
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  2  request per requester; held high until its done bit pulses.
- req_write  in  2  per-requester direction (1 = write).
- req0_addr  in  ADDR_W  requester 0 address.
- req1_addr  in  ADDR_W  requester 1 address.
- req0_wdata  in  DATA_W  requester 0 write data.
- req1_wdata  in  DATA_W  requester 1 write data.
- done  out  2  one-cycle completion pulse per requester.
- rsp_rdata  out  DATA_W  read data; valid while done is high.
- rsp_err  out  1  pslver was captured, or timeout occurred; valid with done.
- rsp_timeout  out  1  transfer was aborted by timeout; valid with done.
- grant  out  2  one-hot owner of the current transfer; 0 when idle.
- busy  out  1  FSM is not in IDLE.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  APB ready.
- prdata  in  DATA_W  APB read data.
- pslver  in  1  APB slave error.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer favours requester 0, wait counter 0. Reset asserted mid-transfer drops psel/penable on the next edge and generates no done.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible requesters are req[i] & ~done[i], so a requester is ignored in its own done cycle.
  - Arbitration when both requesters are eligible: grant the pointer's favourite.
  - After each grant, the pointer moves to the other requester.
  - On grant, register grant, pwrite, paddr and pwdata from the winner, set psel=1, and go to SETUP.
- SETUP: psel=1, penable=0. Next state is ACCESS, with penable=1.
- ACCESS: psel=1, penable=1, address/data/direction held stable.
  - If pready=1: capture prdata (reads only; writes leave rsp_rdata unchanged) and pslver into rsp_err. Pulse done[grant] on the next cycle, clear psel, penable and grant, and return to IDLE.
  - If pready=0: increment the wait counter.
  - Timeout: when TIMEOUT>0 and the counter reaches TIMEOUT with pready still 0, abort. Abort clears psel/penable, pulses done with rsp_err=1 and rsp_timeout=1, and returns to IDLE.
  - The counter clears on every entry to SETUP.
- Latency: zero-wait transfer from req sampled in IDLE to done is 3 cycles (SETUP, ACCESS, done). Each wait state adds 1 cycle.
- Back-to-back: at least one IDLE cycle is required between transfers. That cycle is the done cycle, and arbitration runs in it.
- paddr/pwdata/pwrite keep their last values while idle. rsp_* hold until the next done.
- Request changes: a requester dropping req mid-transfer does not cancel the transfer; done still pulses. A requester changing addr/wdata mid-transfer has no effect, because those values are latched at grant.
- pready or pslver seen in SETUP or IDLE is ignored.

Test Plan:
- Zero-wait write: req=01, req0_addr=5, req0_wdata=1, pready tied 1 -> psel rises cycle 1, penable cycle 2, done=01 cycle 3, rsp_err=0, pwrite=1, paddr=5.
- Read with 2 wait states: req1 read of addr 5, pready high on 3rd ACCESS cycle with prdata=1 -> done=10 at cycle 5, rsp_rdata=1, penable high for exactly 3 cycles.
- Simultaneous requests: req=11 from reset -> req0 served first. req1 is then served with exactly one idle cycle between transfers. Next simultaneous req=11 -> req0 served first again, since the pointer returned to 0 after the req1 grant.
- Slave error: pslver=1 with pready in ACCESS -> done with rsp_err=1, rsp_timeout=0.
- Timeout: pready held 0, TIMEOUT=16 -> after 16 ACCESS cycles psel=penable=0, done pulses, rsp_err=1, rsp_timeout=1. A new request is then accepted normally.
- Reset mid-ACCESS: assert rst for 1 cycle during ACCESS -> psel=penable=grant=0 next cycle, no done pulse, next request is granted to requester 0.

Source files
------------

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester round-robin APB master with pready timeout
module apb_master_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslver
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              rr_q, rr_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              to_q, to_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [1:0]        elig;
    logic              win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_q      <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            to_q      <= to_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        to_d      = to_q;
        wait_d    = wait_q;
        // a requester is still holding req during its own done cycle
        elig      = req & ~done_q;
        win       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (elig != 2'b00) begin
                    win      = (elig == 2'b11) ? rr_q : elig[1];
                    rr_d     = ~win;
                    grant_d  = win ? 2'b10 : 2'b01;
                    pwrite_d = req_write[win];
                    paddr_d  = win ? req1_addr : req0_addr;
                    pwdata_d = win ? req1_wdata : req0_wdata;
                    psel_d   = 1'b1;
                    wait_d   = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                    err_d     = pslver;
                    to_d      = 1'b0;
                    done_d    = grant_q;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    grant_d   = '0;
                    state_d   = ST_IDLE;
                end else if (TIMEOUT > 0 && wait_q == WAIT_LAST) begin
                    err_d     = 1'b1;
                    to_d      = 1'b1;
                    done_d    = grant_q;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    grant_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done        = done_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;
    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - vector table, reset corner case and randomized model check for apb_master_arb
module tb_apb_master_arb;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        req_write;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic [1:0]        done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err, rsp_timeout;
    logic [1:0]        grant;
    logic              busy, psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslver;

    always #5 clk = ~clk;

    apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_write(req_write),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .grant(grant), .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslver(pslver)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int w);
        return (w != 0) ? 2'b10 : 2'b01;
    endfunction

    // per-requester transaction parameters and slave behaviour
    logic [1:0]                    r_wr;
    logic [1:0][ADDR_W-1:0]        r_addr;
    logic [1:0][DATA_W-1:0]        r_wdata;
    logic [1:0][DATA_W-1:0]        r_prd;
    logic [1:0]                    r_serr;
    int                            r_waits [2];

    // observations per served transfer
    logic [1:0]        o_grant [2];
    logic [1:0]        o_done  [2];
    logic [ADDR_W-1:0] o_addr  [2];
    logic              o_wr    [2];
    logic [DATA_W-1:0] o_wdata [2];
    logic [DATA_W-1:0] o_rdata [2];
    logic              o_err   [2];
    logic              o_to    [2];
    int                o_lat   [2];
    int                o_pen   [2];
    int                o_gap   [2];
    int                o_n;

    task automatic run_batch(input logic [1:0] mask);
        int cyc, n_exp, acc, rise_cyc, done_cyc, cur;
        logic psel_prev;
        n_exp = (mask == 2'b11) ? 2 : 1;
        o_n = 0; cyc = 0; acc = 0; rise_cyc = 0; done_cyc = 0; cur = 0; psel_prev = 1'b0;
        @(negedge clk);
        req_write  = r_wr;
        req0_addr  = r_addr[0];
        req1_addr  = r_addr[1];
        req0_wdata = r_wdata[0];
        req1_wdata = r_wdata[1];
        pready = 1'b0; pslver = 1'b0;
        req = mask;
        while (o_n < n_exp && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (psel && !psel_prev) begin
                cur = grant[1] ? 1 : 0;
                o_grant[o_n] = grant; o_addr[o_n] = paddr; o_wr[o_n] = pwrite;
                o_wdata[o_n] = pwdata; o_gap[o_n] = cyc - done_cyc; o_pen[o_n] = 0;
                rise_cyc = cyc; acc = 0;
            end
            psel_prev = psel;
            if (psel && penable) begin
                acc++;
                o_pen[o_n]++;
            end
            if (done != 2'b00) begin
                o_done[o_n] = done; o_err[o_n] = rsp_err; o_to[o_n] = rsp_timeout;
                o_rdata[o_n] = rsp_rdata; o_lat[o_n] = cyc - rise_cyc;
                done_cyc = cyc;
                req = req & ~done;
                o_n++;
            end
            if (psel && penable) begin
                pready = (acc > r_waits[cur]);
                pslver = r_serr[cur];
                prdata = r_prd[cur];
            end else begin
                pready = 1'($urandom);
                pslver = 1'($urandom);
                prdata = DATA_W'($urandom);
            end
        end
        tests++;
        if (o_n < n_exp) begin
            fails++;
            $display("FAIL batch_budget: got %0d done pulses, expected %0d", o_n, n_exp);
        end
        req = 2'b00;
        pready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]             mask;
        logic [1:0]             wr;
        logic [1:0][ADDR_W-1:0] addr;
        logic [1:0][DATA_W-1:0] wdata;
        logic [1:0][DATA_W-1:0] prd;
        int                     waits0;
        int                     waits1;
        logic [1:0]             serr;
        int                     exp_first;
        int                     exp_lat;
        logic                   exp_err;
        logic                   exp_to;
        logic [DATA_W-1:0]      exp_rdata;
    } vec_t;

    vec_t vecs [9];
    vec_t v;

    initial begin
        int n, w, first, fav, accs;
        logic tmo, eerr;
        logic [1:0] mask;
        logic [DATA_W-1:0] last_rd;

        rst = 1'b1; req = '0; req_write = '0; req0_addr = '0; req1_addr = '0;
        req0_wdata = '0; req1_wdata = '0; pready = 1'b0; prdata = '0; pslver = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset psel/penable/busy", {psel, penable, busy}, 3'b000);
        check("reset grant/done", {grant, done}, 4'b0000);
        check("reset rsp", {rsp_err, rsp_timeout, rsp_rdata}, '0);
        check("reset bus", {pwrite, paddr, pwdata}, '0);
        rst = 1'b0;

        //            mask   wr     addr{1,0}         wdata{1,0}                prd{1,0}                  w0  w1  serr  first lat err to rdata
        vecs[0] = '{2'b01, 2'b01, {8'h00, 8'h05}, {32'h0, 32'h1},           {32'h0, 32'h0},           0,  0,  2'b00, 0, 2,  0, 0, 32'h0};
        vecs[1] = '{2'b10, 2'b00, {8'h05, 8'h00}, {32'h0, 32'h0},           {32'h1, 32'h0},           0,  2,  2'b00, 1, 4,  0, 0, 32'h1};
        vecs[2] = '{2'b11, 2'b11, {8'h22, 8'h11}, {32'hBBBB, 32'hAAAA},     {32'h0, 32'h0},           0,  0,  2'b00, 0, 2,  0, 0, 32'h1};
        vecs[3] = '{2'b11, 2'b10, {8'h33, 8'h44}, {32'hCC, 32'hDD},         {32'h0, 32'hA5},          1,  0,  2'b00, 0, 3,  0, 0, 32'hA5};
        vecs[4] = '{2'b01, 2'b01, {8'h00, 8'h7F}, {32'h0, 32'h77},          {32'h0, 32'h0},           1,  0,  2'b01, 0, 3,  1, 0, 32'hA5};
        vecs[5] = '{2'b10, 2'b00, {8'h80, 8'h00}, {32'h0, 32'h0},           {32'hDEAD, 32'h0},        0,  99, 2'b00, 1, 17, 1, 1, 32'hA5};
        vecs[6] = '{2'b01, 2'b00, {8'h00, 8'h10}, {32'h0, 32'h0},           {32'h0, 32'h1234},        0,  0,  2'b00, 0, 2,  0, 0, 32'h1234};
        vecs[7] = '{2'b11, 2'b10, {8'hF0, 8'h0F}, {32'h5555, 32'h6666},     {32'h0, 32'h4321},        0,  0,  2'b00, 1, 2,  0, 0, 32'h1234};
        vecs[8] = '{2'b01, 2'b00, {8'h00, 8'h3C}, {32'h0, 32'h0},           {32'h0, 32'hBEEF},        15, 0,  2'b00, 0, 17, 0, 0, 32'hBEEF};

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            r_wr = v.wr; r_addr = v.addr; r_wdata = v.wdata; r_prd = v.prd; r_serr = v.serr;
            r_waits[0] = v.waits0; r_waits[1] = v.waits1;
            run_batch(v.mask);
            n = (v.mask == 2'b11) ? 2 : 1;
            for (int k = 0; k < n && k < o_n; k++) begin
                w = (k == 0) ? v.exp_first : 1 - v.exp_first;
                check($sformatf("v%0d.%0d grant", i, k), o_grant[k], oh(w));
                check($sformatf("v%0d.%0d done", i, k), o_done[k], oh(w));
                check($sformatf("v%0d.%0d paddr", i, k), o_addr[k], r_addr[w]);
                check($sformatf("v%0d.%0d pwrite", i, k), o_wr[k], r_wr[w]);
                check($sformatf("v%0d.%0d pwdata", i, k), o_wdata[k], r_wdata[w]);
                check($sformatf("v%0d.%0d idle_gap", i, k), o_gap[k], 1);
                if (k == 0) begin
                    check($sformatf("v%0d latency", i), o_lat[0], v.exp_lat);
                    check($sformatf("v%0d penable_cycles", i), o_pen[0], v.exp_lat - 1);
                    check($sformatf("v%0d rsp_err", i), o_err[0], v.exp_err);
                    check($sformatf("v%0d rsp_timeout", i), o_to[0], v.exp_to);
                    check($sformatf("v%0d rsp_rdata", i), o_rdata[0], v.exp_rdata);
                end
            end
        end

        // reset during ACCESS: requester 0 owns the bus with pready held low
        @(negedge clk);
        req0_addr = 8'h66; req_write = 2'b01; pready = 1'b0; req = 2'b01;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (penable) break;
        end
        check("rm reached access", penable, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rm psel/penable/grant", {psel, penable, grant}, 4'b0000);
        check("rm done/busy", {done, busy}, 3'b000);
        check("rm rsp_rdata", rsp_rdata, '0);
        rst = 1'b0; req = 2'b00;
        @(negedge clk);
        check("rm no late done", {done, psel}, 3'b000);
        r_wr = 2'b11; r_addr = {8'h02, 8'h01}; r_wdata = {32'h22, 32'h11}; r_serr = 2'b00;
        r_waits[0] = 0; r_waits[1] = 0;
        run_batch(2'b11);
        check("rm first grant", o_grant[0], 2'b01);
        check("rm second grant", o_grant[1], 2'b10);
        check("rm rdata held", o_rdata[1], '0);

        // randomized traffic against a transaction-level model
        fav = 0;
        last_rd = '0;
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                r_wr[i]    = 1'($urandom_range(0, 1));
                r_addr[i]  = ADDR_W'($urandom);
                r_wdata[i] = DATA_W'($urandom);
                r_prd[i]   = DATA_W'($urandom);
                r_serr[i]  = ($urandom_range(0, 3) == 0);
                r_waits[i] = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            end
            run_batch(mask);
            n = (mask == 2'b11) ? 2 : 1;
            first = (mask == 2'b11) ? fav : ((mask == 2'b10) ? 1 : 0);
            for (int k = 0; k < n; k++) begin
                w = (k == 0) ? first : 1 - first;
                fav = 1 - w;
                tmo = (r_waits[w] >= TIMEOUT);
                accs = tmo ? TIMEOUT : r_waits[w] + 1;
                eerr = tmo || r_serr[w];
                if (!tmo && !r_wr[w]) last_rd = r_prd[w];
                if (k < o_n) begin
                    check($sformatf("r%0d.%0d grant", it, k), o_grant[k], oh(w));
                    check($sformatf("r%0d.%0d done", it, k), o_done[k], oh(w));
                    check($sformatf("r%0d.%0d bus", it, k), {o_wr[k], o_addr[k], o_wdata[k]},
                          {r_wr[w], r_addr[w], r_wdata[w]});
                    check($sformatf("r%0d.%0d latency", it, k), o_lat[k], 1 + accs);
                    check($sformatf("r%0d.%0d penable_cycles", it, k), o_pen[k], accs);
                    check($sformatf("r%0d.%0d idle_gap", it, k), o_gap[k], 1);
                    check($sformatf("r%0d.%0d err/to", it, k), {o_err[k], o_to[k]}, {eerr, tmo});
                    check($sformatf("r%0d.%0d rdata", it, k), o_rdata[k], last_rd);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
